// File: rtl/sdram_responder.sv
// SDRAM-side responder: word memory, fixed-latency reads, line-transfer FSM.
// Define SDRAM_INIT_EN to preload memory with addr[7:0]^addr[15:8] on reset.
module sdram_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address_sdram,
  input  logic [DATA_WIDTH-1:0] din_sdram,
  input  logic                  wr_rd_sdram,
  input  logic                  mstrb_sdram,
  output logic [DATA_WIDTH-1:0] DOut_sdram,
  output logic                  dvalid_sdram,
  output logic                  busy_sdram,
  output logic                  blk_done,
  output logic                  err_sdram
);

  localparam int OW = $clog2(BURST_LEN);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [LATENCY-1:0] LAST =
    LATENCY'(1 << (LATENCY - 1));

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [ADDR_WIDTH-OW-1:0] tag, tag_nx;
  logic dir, dir_nx;
  logic err, err_nx;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0][DATA_WIDTH-1:0] pd;
  logic wr, rd, full, pend, mism;

  assign wr   = mstrb_sdram & wr_rd_sdram;
  assign rd   = mstrb_sdram & ~wr_rd_sdram;
  assign full = cnt == CW'(BURST_LEN);
  // reads still in flight behind the output stage
  assign pend = |(pv & ~LAST);
  assign mism = (Address_sdram[ADDR_WIDTH-1:OW] != tag)
              || (wr_rd_sdram != dir);

`ifdef SDRAM_INIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++)
        mem[i] <= DATA_WIDTH'((i ^ (i >> 8)) & 255);
    end else if (wr) begin
      mem[Address_sdram] <= din_sdram;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst && wr)
      mem[Address_sdram] <= din_sdram;
  end
`endif

  // each stage loads only on valid, so the last one holds old data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      pd <= '0;
    end else begin
      pv <= LATENCY'({pv, rd});
      if (rd)
        pd[0] <= mem[Address_sdram];
      for (int i = 1; i < LATENCY; i++)
        if (pv[i-1])
          pd[i] <= pd[i-1];
    end
  end

  assign DOut_sdram   = pd[LATENCY-1];
  assign dvalid_sdram = pv[LATENCY-1];
  assign busy_sdram   = state != IDLE;
  assign err_sdram    = err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      tag   <= '0;
      dir   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tag   <= tag_nx;
      dir   <= dir_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tag_nx   = tag;
    dir_nx   = dir;
    err_nx   = err;
    blk_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (mstrb_sdram) begin
          state_nx = BURST;
          cnt_nx   = CW'(1);
          tag_nx   = Address_sdram[ADDR_WIDTH-1:OW];
          dir_nx   = wr_rd_sdram;
        end
      end
      BURST: begin
        if (!full) begin
          if (mstrb_sdram) begin
            cnt_nx = cnt + 1'b1;
            err_nx = err | mism;
          end
        end else begin
          err_nx = err | mstrb_sdram;
          if (dir || (!rd && !pend)) begin
            blk_done = 1'b1;
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        err_nx = err | mstrb_sdram;
        if (!rd && !pend) begin
          blk_done = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: random bursts against a queue-based model.
// Honours SDRAM_INIT_EN when defined for the build.
module tb_sdram_responder;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int BL  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic wr = 1'b0;
  logic strb = 1'b0;
  logic [DW-1:0] dout;
  logic dvalid, busy, blk_done, err;

  sdram_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BURST_LEN(BL),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Address_sdram(addr),
    .din_sdram(din),
    .wr_rd_sdram(wr),
    .mstrb_sdram(strb),
    .DOut_sdram(dout),
    .dvalid_sdram(dvalid),
    .busy_sdram(busy),
    .blk_done(blk_done),
    .err_sdram(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int s_edge = 0;
  int dv_cnt = 0;
  int done_cnt = 0;
  bit done_with_dv = 0;
  logic [7:0] rdq[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               nm, act, exp, ecnt);
    end
  endtask

  // model: memory map, pending read queue, transfer bookkeeping
  typedef struct {
    int due;
    bit known;
    logic [7:0] d;
  } rd_t;

  logic [7:0] mm[int];
  rd_t pq[$];
  bit m_active, m_dir, m_err, m_done_known;
  int m_tag, m_cnt, m_done, m_lastrd;
  logic [7:0] m_dout;
  bit m_dout_known, m_dv, m_busy, m_blk;

  function automatic void model_reset();
    pq.delete();
    m_active = 0;
    m_err = 0;
    m_dout = '0;
    m_dout_known = 1;
    m_dv = 0;
    m_busy = 0;
    m_blk = 0;
    m_done_known = 0;
    m_cnt = 0;
`ifdef SDRAM_INIT_EN
    mm.delete();
`endif
  endfunction

  function automatic void mem_read(input int a, output bit kn,
                                   output logic [7:0] d);
    if (mm.exists(a)) begin
      kn = 1;
      d = mm[a];
    end else begin
`ifdef SDRAM_INIT_EN
      kn = 1;
      d = 8'((a ^ (a >> 8)) & 255);
`else
      kn = 0;
      d = '0;
`endif
    end
  endfunction

  function automatic void model_step();
    int a;
    bit kn;
    logic [7:0] d;
    rd_t r;
    ecnt++;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_active && m_done_known && ecnt > m_done)
      m_active = 0;
    if (strb) begin
      a = int'(addr);
      if (!m_active) begin
        m_active = 1;
        m_tag = a >> 5;
        m_dir = wr;
        m_cnt = 1;
        m_done_known = 0;
        m_lastrd = -100;
      end else begin
        m_cnt++;
        if ((a >> 5) != m_tag || wr != m_dir)
          m_err = 1;
      end
      if (wr) begin
        mm[a] = din;
      end else begin
        mem_read(a, kn, d);
        r.due = ecnt + LAT - 1;
        r.known = kn;
        r.d = d;
        pq.push_back(r);
        m_lastrd = ecnt;
      end
      if (m_cnt == BL && !m_done_known) begin
        m_done_known = 1;
        if (m_dir)
          m_done = ecnt;
        else
          m_done = (m_lastrd + LAT - 1 > ecnt) ? m_lastrd + LAT - 1 : ecnt;
      end
    end
    m_dv = 0;
    if (pq.size() > 0 && pq[0].due == ecnt) begin
      r = pq.pop_front();
      m_dv = 1;
      m_dout = r.d;
      m_dout_known = r.known;
    end
    m_busy = m_active;
    m_blk = m_active && m_done_known && ecnt == m_done;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("dvalid", dvalid, m_dv);
    check("busy", busy, m_busy);
    check("blk_done", blk_done, m_blk);
    check("err", err, m_err);
    if (m_dout_known)
      check("dout", dout, m_dout);
    if (dvalid) begin
      dv_cnt++;
      rdq.push_back(dout);
    end
    if (blk_done) begin
      done_cnt++;
      done_with_dv = dvalid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [15:0] a, input bit w,
                        input logic [7:0] d);
    addr = a;
    wr = w;
    din = d;
    strb = 1'b1;
    tick();
    strb = 1'b0;
    s_edge = ecnt;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("burst_end", busy, 0);
    idle(1);
  endtask

  task automatic wait_dv(input string nm, output logic [7:0] d,
                         output int lat);
    int n;
    n = 0;
    d = '0;
    lat = -1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (dvalid) begin
        d = dout;
        lat = ecnt - s_edge;
        break;
      end
    end
    check({nm, "_seen"}, 32'(lat >= 0), 1);
    tick();
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_dout", dout, 0);
    check("rst_dvalid", dvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_blk_done", blk_done, 0);
    check("rst_err", err, 0);
    tick();
    tick();
    rst = 1'b1;
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int pool[4] = '{16'h9FE0, 16'hA000, 16'h1240, 16'h0040};

  initial begin
    logic [7:0] d;
    int lat, d0, base, bad, rot, a;
    bit w;
    model_reset();
    idle(3);
    rst = 1'b1;
    idle(1);
    check("init_busy", busy, 0);
    check("init_dvalid", dvalid, 0);
    check("init_dout", dout, 0);

`ifdef SDRAM_INIT_EN
    strobe(16'h9FE2, 0, 0);
    wait_dv("init_rd", d, lat);
    check("init_rd_data", d, 8'h7D);
    check("init_rd_lat", lat, 1);
    check("init_rd_err", err, 0);
    reset_dut();
`endif

    // write-back line, then read one word back
    d0 = done_cnt;
    for (int i = 0; i < BL; i++)
      strobe(16'(16'h9FE0 + i), 1, 8'hBB);
    wait_idle();
    check("wb_done", done_cnt, d0 + 1);
    check("wb_err", err, 0);
    strobe(16'h9FE2, 0, 0);
    wait_dv("wb_rd", d, lat);
    check("wb_rd_data", d, 8'hBB);
    check("wb_rd_lat", lat, 1);
    reset_dut();

    // line fill
`ifndef SDRAM_INIT_EN
    for (int i = 0; i < BL; i++)
      strobe(16'(16'hA000 + i), 1, 8'(i ^ 8'hA0));
    wait_idle();
`endif
    rdq.delete();
    d0 = done_cnt;
    for (int i = 0; i < BL; i++)
      strobe(16'(16'hA000 + i), 0, 0);
    wait_idle();
    check("fill_count", rdq.size(), 32);
    if (rdq.size() > 3)
      check("fill_off3", rdq[3], 8'hA3);
    check("fill_done", done_cnt, d0 + 1);
    check("fill_done_dv", done_with_dv, 1);
    check("fill_err", err, 0);

    // protocol error inside a read burst
    reset_dut();
    d0 = done_cnt;
    for (int i = 0; i < BL; i++) begin
      if (i == 4) begin
        check("perr_before", err, 0);
        strobe(16'hB004, 0, 0);
        check("perr_set", err, 1);
      end else begin
        strobe(16'(16'hA000 + i), 0, 0);
      end
    end
    wait_idle();
    check("perr_sticky", err, 1);
    check("perr_done", done_cnt, d0 + 1);

    // reset in the middle of a read burst
    reset_dut();
    for (int i = 0; i < 10; i++)
      strobe(16'(16'hA000 + i), 0, 0);
    d0 = done_cnt;
    reset_dut();
    idle(5);
    check("midrst_no_done", done_cnt, d0);
    for (int i = 0; i < BL; i++)
      strobe(16'(16'hA000 + i), 0, 0);
    wait_idle();
    check("midrst_new_done", done_cnt, d0 + 1);

    // write then read the same word on the next cycle
    reset_dut();
    strobe(16'h0010, 1, 8'h5A);
    strobe(16'h0010, 0, 0);
    wait_dv("b2b", d, lat);
    check("b2b_data", d, 8'h5A);
    check("b2b_dir_err", err, 1);
    reset_dut();

    // prefill the pool lines so random reads have known data
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < BL; i++)
        strobe(16'(pool[p] + i), 1, 8'($urandom_range(255)));
      wait_idle();
    end

    for (int b = 0; b < 40; b++) begin
      base = pool[$urandom_range(3)];
      w = 1'($urandom_range(1));
      bad = ($urandom_range(7) == 0) ? int'($urandom_range(BL - 2)) + 1 : -1;
      rot = $urandom_range(BL - 1);
      for (int i = 0; i < BL; i++) begin
        a = base + ((i + rot) % BL);
        if (i == bad)
          a = a ^ 16'h0100;
        if ($urandom_range(3) == 0)
          idle($urandom_range(2) + 1);
        strobe(16'(a), w, 8'($urandom_range(255)));
      end
      wait_idle();
      if (b % 10 == 9)
        reset_dut();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
